// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line: command receiver, CRC7 check, response transmitter
// Define SD_RSP_LONG_EN to add 136-bit R2 responses (rsp_long_i / rsp_long_dat_i).
module sd_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         sd_bit_stb_i,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic         rx_valid_o,
  output logic [5:0]   rx_index_o,
  output logic [31:0]  rx_arg_o,
  output logic         rx_err_o,
  output logic         rsp_ready_o,
  input  logic         rsp_valid_i,
  input  logic         rsp_none_i,
  input  logic [5:0]   rsp_index_i,
  input  logic [31:0]  rsp_arg_i,
`ifdef SD_RSP_LONG_EN
  input  logic         rsp_long_i,
  input  logic [127:0] rsp_long_dat_i,
`endif
  output logic         busy_o
);

`ifdef SD_RSP_LONG_EN
  localparam int TX_W = 136;
`else
  localparam int TX_W = 48;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RX, S_WAIT_RSP, S_NCR, S_TX} state_t;
  state_t state_q, state_d;

  logic [7:0]      bit_cnt, cnt_inc, tx_len;
  logic [6:0]      crc_q;
  logic [46:0]     rx_sr;
  logic [47:0]     frame, short_rsp;
  logic [TX_W-1:0] tx_sr;
  logic            last_rx, frame_ok, ncr_reached, tx_done;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_block(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  // bit_cnt is shared: RX bit index, strobes since the end bit, then TX bit count.
  assign cnt_inc     = (bit_cnt == 8'hFF) ? bit_cnt : bit_cnt + 8'd1;
  assign frame       = {rx_sr, cmd_dat_i};
  assign last_rx     = bit_cnt == 8'd46;
  assign frame_ok    = !frame[47] && frame[46] && frame[0] && (frame[7:1] == crc_q);
  assign ncr_reached = ({1'b0, bit_cnt} + 9'd1) >= 9'(NCR);
  assign tx_done     = bit_cnt == tx_len;
  assign short_rsp   = {2'b00, rsp_index_i, rsp_arg_i,
                        crc7_block({2'b00, rsp_index_i, rsp_arg_i}), 1'b1};
  assign rsp_ready_o = state_q == S_WAIT_RSP;
  assign busy_o      = state_q != S_IDLE;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (sd_bit_stb_i && !cmd_dat_i) state_d = S_RX;
      S_RX:       if (sd_bit_stb_i && last_rx) state_d = frame_ok ? S_WAIT_RSP : S_IDLE;
      S_WAIT_RSP: if (rsp_valid_i) state_d = rsp_none_i ? S_IDLE : S_NCR;
      S_NCR:      if (sd_bit_stb_i && ncr_reached) state_d = S_TX;
      S_TX:       if (sd_bit_stb_i && tx_done) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt    <= 8'd0;
      crc_q      <= 7'd0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      tx_len     <= 8'd0;
      cmd_out_o  <= 1'b1;
      cmd_oe_o   <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      rx_index_o <= 6'd0;
      rx_arg_o   <= 32'd0;
    end else begin
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The start bit is 0, so folding it into a zero CRC leaves it zero.
          if (sd_bit_stb_i && !cmd_dat_i) begin
            bit_cnt <= 8'd0;
            crc_q   <= 7'd0;
            rx_sr   <= '0;
          end
        end
        S_RX: begin
          if (sd_bit_stb_i) begin
            rx_sr   <= frame[46:0];
            bit_cnt <= cnt_inc;
            if (bit_cnt < 8'd39) crc_q <= crc7_step(crc_q, cmd_dat_i);
            if (last_rx) begin
              bit_cnt <= 8'd0;
              if (frame_ok) begin
                rx_valid_o <= 1'b1;
                rx_index_o <= frame[45:40];
                rx_arg_o   <= frame[39:8];
              end else begin
                rx_err_o <= 1'b1;
              end
            end
          end
        end
        S_WAIT_RSP: begin
          if (sd_bit_stb_i) bit_cnt <= cnt_inc;
          if (rsp_valid_i && !rsp_none_i) begin
`ifdef SD_RSP_LONG_EN
            if (rsp_long_i) begin
              tx_sr  <= {2'b00, 6'b111111, rsp_long_dat_i[127:1], 1'b1};
              tx_len <= 8'd136;
            end else begin
              tx_sr  <= {short_rsp, 88'd0};
              tx_len <= 8'd48;
            end
`else
            tx_sr  <= short_rsp;
            tx_len <= 8'd48;
`endif
          end
        end
        S_NCR: begin
          if (sd_bit_stb_i) begin
            if (ncr_reached) begin
              cmd_oe_o  <= 1'b1;
              cmd_out_o <= tx_sr[TX_W-1];
              tx_sr     <= {tx_sr[TX_W-2:0], 1'b0};
              bit_cnt   <= 8'd1;
            end else begin
              bit_cnt <= cnt_inc;
            end
          end
        end
        S_TX: begin
          if (sd_bit_stb_i) begin
            if (tx_done) begin
              cmd_oe_o  <= 1'b0;
              cmd_out_o <= 1'b1;
            end else begin
              cmd_out_o <= tx_sr[TX_W-1];
              tx_sr     <= {tx_sr[TX_W-2:0], 1'b0};
              bit_cnt   <= cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
